// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//   lsu_state_e : FSM state encoding (idle, waiting for memory ack, response strobe)
//   F3_*        : RISC-V load/store funct3 codes (size in [1:0], unsigned in [2])
//   BE_W        : width of the memory byte-enable bus
package lsu_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StWaitAck = 2'd1,
    StResp    = 2'd2
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int unsigned BE_W = 4;

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic for the load/store unit.
// Request side:
//   funct3, off, write, wdata -> legal (size/alignment/opcode check), be, wdata_lane
// Load-return side:
//   ld_funct3, ld_off, rdata  -> rdata_ext (lane extracted, sign/zero extended)
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [1:0]      off,
  input  logic            write,
  input  logic [31:0]     wdata,
  output logic            legal,
  output logic [BE_W-1:0] be,
  output logic [31:0]     wdata_lane,
  input  logic [2:0]      ld_funct3,
  input  logic [1:0]      ld_off,
  input  logic [31:0]     rdata,
  output logic [31:0]     rdata_ext
);

  logic [31:0] rdata_sh;

  // Unsigned variants exist only for loads.
  always_comb begin
    legal = 1'b0;
    case (funct3)
      F3_B:    legal = 1'b1;
      F3_H:    legal = ~off[0];
      F3_W:    legal = (off == 2'b00);
      F3_BU:   legal = ~write;
      F3_HU:   legal = ~write & ~off[0];
      default: legal = 1'b0;
    endcase
  end

  // Store data is replicated across all lanes; byte enables pick the live ones.
  always_comb begin
    be         = 4'b1111;
    wdata_lane = wdata;
    case (funct3[1:0])
      2'b00: begin
        be         = 4'b0001 << off;
        wdata_lane = {4{wdata[7:0]}};
      end
      2'b01: begin
        be         = 4'b0011 << off;
        wdata_lane = {2{wdata[15:0]}};
      end
      default: ;
    endcase
  end

  assign rdata_sh = rdata >> {ld_off, 3'b000};

  always_comb begin
    case (ld_funct3)
      F3_B:    rdata_ext = {{24{rdata_sh[7]}}, rdata_sh[7:0]};
      F3_BU:   rdata_ext = {24'h000000, rdata_sh[7:0]};
      F3_H:    rdata_ext = {{16{rdata_sh[15]}}, rdata_sh[15:0]};
      F3_HU:   rdata_ext = {16'h0000, rdata_sh[15:0]};
      default: rdata_ext = rdata_sh;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the core and data memory.
// Accepts one request at a time (req_valid/req_ready), issues one word-aligned memory
// transaction with byte enables (mem_req .. mem_ack), and returns a one-cycle response
// (resp_valid, resp_rdata extended load data, resp_err for illegal/misaligned/timeout).
// Ports: clock, rst (async active-low), req_*, resp_*, mem_*.
// Build option: define LSU_TIMEOUT_EN to abort WAIT_ACK after TIMEOUT_CYCLES cycles
// without mem_ack; otherwise the unit waits for the ack indefinitely.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [BE_W-1:0]   mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
);

  lsu_state_e      state_q;
  logic            write_q;
  logic [2:0]      ld_funct3_q;
  logic [1:0]      ld_off_q;
  logic            legal;
  logic [BE_W-1:0] be;
  logic [31:0]     wdata_lane;
  logic [31:0]     rdata_ext;

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TmoW-1:0] tmo_q;
`endif

  lsu_lane_align u_lane_align (
    .funct3     (req_funct3),
    .off        (req_addr[1:0]),
    .write      (req_write),
    .wdata      (req_wdata),
    .legal      (legal),
    .be         (be),
    .wdata_lane (wdata_lane),
    .ld_funct3  (ld_funct3_q),
    .ld_off     (ld_off_q),
    .rdata      (mem_rdata),
    .rdata_ext  (rdata_ext)
  );

  assign req_ready = (state_q == StIdle);

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      write_q     <= 1'b0;
      ld_funct3_q <= 3'b000;
      ld_off_q    <= 2'b00;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_be      <= '0;
      mem_wdata   <= '0;
      resp_valid  <= 1'b0;
      resp_rdata  <= '0;
      resp_err    <= 1'b0;
`ifdef LSU_TIMEOUT_EN
      tmo_q       <= '0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          if (req_valid) begin
            write_q     <= req_write;
            ld_funct3_q <= req_funct3;
            ld_off_q    <= req_addr[1:0];
            if (legal) begin
              state_q   <= StWaitAck;
              mem_req   <= 1'b1;
              mem_we    <= req_write;
              mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
              mem_be    <= be;
              mem_wdata <= wdata_lane;
`ifdef LSU_TIMEOUT_EN
              tmo_q     <= '0;
`endif
            end else begin
              // Rejected requests never touch memory.
              state_q    <= StResp;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end
          end
        end
        StWaitAck: begin
          // Ack is checked first so it wins over a same-cycle timeout.
          if (mem_ack) begin
            state_q    <= StResp;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_be     <= '0;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= write_q ? 32'h0 : rdata_ext;
          end
`ifdef LSU_TIMEOUT_EN
          else if (tmo_q == TmoW'(TIMEOUT_CYCLES - 1)) begin
            state_q    <= StResp;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_be     <= '0;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_rdata <= '0;
          end else begin
            tmo_q <= tmo_q + TmoW'(1);
          end
`endif
        end
        StResp: begin
          state_q    <= StIdle;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits directly downstream of the single-cycle core's ALU/control path, between the core and data memory.
- Accepts one load/store request at a time from the core over a valid/ready handshake.
- Converts each request into a word-aligned memory transaction with byte enables, and waits for the memory acknowledge.
- Returns load data lane-extracted and sign- or zero-extended.

Parameters:
- ADDR_W, 32, byte-address width on both the core side and the memory side.
- TIMEOUT_CYCLES, 16, number of WAIT_ACK cycles before the timeout abort. Used only when LSU_TIMEOUT_EN is defined.

Ports:
- clock  input  1  single clock; all flops on its rising edge.
- rst  input  1  asynchronous active-low reset; asserted while 0.
- req_valid  input  1  core request valid.
- req_ready  output  1  LSU can accept a request.
- req_write  input  1  1 = store, 0 = load.
- req_funct3  input  3  RISC-V funct3 (size/sign).
- req_addr  input  ADDR_W  byte address (ALU result).
- req_wdata  input  32  store data (rs2).
- resp_valid  output  1  one-cycle response strobe.
- resp_rdata  output  32  extended load data; 0 for stores and errors.
- resp_err  output  1  misaligned/illegal access, or timeout.
- mem_req  output  1  memory transaction request.
- mem_we  output  1  memory write enable.
- mem_addr  output  ADDR_W  word-aligned address: req_addr with bits [1:0] forced to 00.
- mem_be  output  4  byte enables.
- mem_wdata  output  32  lane-shifted store data.
- mem_ack  input  1  memory completion, one cycle.
- mem_rdata  input  32  read word, valid in the cycle mem_ack is high.

Behaviour:
- FSM states: IDLE, WAIT_ACK, RESP. Reset state is IDLE.
- Reset values: mem_req, mem_we, mem_be, mem_wdata, mem_addr, resp_valid, resp_rdata and resp_err are all 0. req_ready = (state==IDLE), so it reads 1 during reset.
- Acceptance: a request is accepted in the cycle req_valid && req_ready. All request fields are latched at acceptance, and later input changes are ignored.
- Legal loads (funct3):
  - 000 LB, 100 LBU: any address.
  - 001 LH, 101 LHU: addr[0]=0.
  - 010 LW: addr[1:0]=00.
- Legal stores: 000 SB, 001 SH, 010 SW, with the same alignment rules as the loads of equal size.
- Everything else is illegal: funct3 011, 110 and 111, and store funct3 100 and 101.
- Illegal or misaligned request: IDLE -> RESP with resp_err=1 and resp_rdata=0. mem_req is never asserted.
- Legal request: IDLE -> WAIT_ACK.
  - mem_req=1 from the next cycle.
  - mem_we, mem_addr, mem_be and mem_wdata are held stable until mem_ack is sampled.
- Byte enables and store data (off = addr[1:0]):
  - Byte: mem_be = 0001 << off; mem_wdata = {4{wdata[7:0]}}.
  - Half: mem_be = 0011 << off; mem_wdata = {2{wdata[15:0]}}.
  - Word: mem_be = 1111; mem_wdata = wdata.
  - For loads, mem_be carries the same pattern and mem_we=0.
- mem_ack high in WAIT_ACK:
  - Drop mem_req on the next edge and go to RESP.
  - For loads, capture mem_rdata >> (8*off), then sign-extend (LB, LH) or zero-extend (LBU, LHU).
- RESP: resp_valid=1 for exactly one cycle, then IDLE. There is no backpressure on the response.
- mem_ack outside WAIT_ACK is ignored.
- Latency:
  - Accept in cycle 0, mem_req in cycle 1.
  - Ack in cycle 1 gives resp_valid in cycle 2; each cycle of ack delay adds one cycle.
  - An error request gives resp_valid in cycle 1.
- Back-to-back: req_ready rises in the cycle after RESP, so at most one outstanding transaction.
- Reset asserted mid-transaction: the transaction is abandoned and mem_req falls immediately (asynchronously). No response is ever produced for the abandoned request.

Optional Feature:
- Macro: LSU_TIMEOUT_EN.
- Defined: a counter runs in WAIT_ACK. If TIMEOUT_CYCLES consecutive cycles pass without mem_ack:
  - mem_req deasserts;
  - the FSM goes to RESP with resp_err=1 and resp_rdata=0;
  - the counter clears on entry to WAIT_ACK.
  - An ack arriving in the same cycle as expiry wins, and the response is normal.
- Undefined: no counter; WAIT_ACK waits indefinitely.

Decomposition:
- Package lsu_pkg holds:
  - FSM state encoding (IDLE, WAIT_ACK, RESP);
  - funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - the mem_be width constant.
- One combinational sub-module, lsu_lane_align, does:
  - alignment and legality check;
  - byte-enable and store-data generation;
  - load lane extraction and extension.
- The FSM, latches and timeout counter stay in load_store_unit.

Test Plan:
- LW at addr 0x10, ack in the same cycle mem_req rises, mem_rdata 0xDEADBEEF -> mem_addr 0x10, mem_be 1111, resp_valid in cycle 2, resp_rdata 0xDEADBEEF, resp_err 0.
- LB at 0x13 with mem_rdata 0x80FFFFFF -> resp_rdata 0xFFFFFF80; LBU at the same address -> 0x00000080; LH at 0x12 with mem_rdata 0x7FFF0000 -> 0x00007FFF.
- SH at 0x22, wdata 0x1234ABCD, ack delayed 3 cycles -> mem_addr 0x20, mem_be 1100, mem_wdata 0xABCDABCD, mem_we 1 held 4 cycles, resp_rdata 0.
- Misaligned LW at 0x101 and illegal funct3 011 -> mem_req stays 0, resp_valid in cycle 1 with resp_err 1.
- rst driven low while in WAIT_ACK -> mem_req 0 immediately, no resp_valid, req_ready 1. A new LW after rst returns high completes normally.
- With LSU_TIMEOUT_EN and TIMEOUT_CYCLES=4, no ack -> mem_req drops after 4 cycles, resp_err 1. Without the macro, mem_req is still high after 100 cycles.
